// File: rtl/hash_cmp_pkg.sv
// Shared constants and helpers for the multi-lane hash/target comparator.
package hash_cmp_pkg;

    localparam logic MODE_LT = 1'b0;
    localparam logic MODE_LZ = 1'b1;

    // Width of an index into n items, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lead_zero_count.sv
// Combinational leading-zero count; an all-zero input yields W.
module lead_zero_count #(
    parameter int unsigned W = 24
) (
    input  logic [W-1:0]           hash,
    output logic [$clog2(W+1)-1:0] count
);
    localparam int unsigned CW = $clog2(W + 1);

    // The last assignment wins, so the most significant set bit decides.
    always_comb begin
        count = CW'(W);
        for (int unsigned i = 0; i < W; i++) begin
            if (hash[i]) count = CW'(W - 1 - i);
        end
    end

endmodule

// File: rtl/hash_target_cmp.sv
// Multi-lane hash/target comparator: 2-stage pipeline, sticky first-winner capture, hash counter.
module hash_target_cmp
    import hash_cmp_pkg::*;
#(
    parameter int unsigned HASH_W  = 24,
    parameter int unsigned NONCE_W = 32,
    parameter int unsigned LANES   = 4,
    parameter int unsigned CNT_W   = 32
) (
    input  logic                          clk,
    input  logic                          reset_L,
    input  logic                          enable,
    input  logic                          clear,
    input  logic                          mode,
    input  logic [HASH_W-1:0]             target,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*HASH_W-1:0]       in_hash,
    input  logic [NONCE_W-1:0]            in_nonce,
    output logic                          valid,
    output logic [HASH_W-1:0]             bounty,
    output logic [NONCE_W-1:0]            found_nonce,
    output logic [clog2_min1(LANES)-1:0]  found_lane,
    output logic [CNT_W-1:0]              hash_count
);
    localparam int unsigned LZ_W   = $clog2(HASH_W + 1);
    localparam int unsigned LANE_W = clog2_min1(LANES);

    logic                      accept;
    logic [LANES-1:0]          hit;
    logic [LZ_W-1:0]           lzc [LANES];

    logic                      s1_valid;
    logic [LANES-1:0]          s1_hit;
    logic [LANES*HASH_W-1:0]   s1_hash;
    logic [NONCE_W-1:0]        s1_nonce;

    logic [LANE_W-1:0]         sel_lane;
    logic [HASH_W-1:0]         sel_hash;
    logic [CNT_W:0]            cnt_sum;
    logic [CNT_W-1:0]          cnt_next;

    assign in_ready = !valid;
    assign accept   = in_valid && in_ready && enable && !clear;

    // Mode and target only matter at accept time; the hit vector carries their effect.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        lead_zero_count #(
            .W (HASH_W)
        ) u_lzc (
            .hash  (in_hash[i*HASH_W +: HASH_W]),
            .count (lzc[i])
        );
        assign hit[i] = (mode == MODE_LZ) ? (lzc[i] >= target[LZ_W-1:0])
                                          : (in_hash[i*HASH_W +: HASH_W] < target);
    end

    // Lowest set lane wins.
    always_comb begin
        sel_lane = '0;
        sel_hash = s1_hash[HASH_W-1:0];
        for (int i = LANES - 1; i >= 0; i--) begin
            if (s1_hit[i]) begin
                sel_lane = LANE_W'(i);
                sel_hash = s1_hash[i*HASH_W +: HASH_W];
            end
        end
    end

    assign cnt_sum  = {1'b0, hash_count} + (CNT_W + 1)'(LANES);
    assign cnt_next = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            s1_valid <= 1'b0;
            s1_hit   <= '0;
            s1_hash  <= '0;
            s1_nonce <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_hit   <= hit;
                s1_hash  <= in_hash;
                s1_nonce <= in_nonce;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            valid       <= 1'b0;
            bounty      <= '0;
            found_nonce <= '0;
            found_lane  <= '0;
        end else if (clear) begin
            valid       <= 1'b0;
            bounty      <= '0;
            found_nonce <= '0;
            found_lane  <= '0;
        end else if (s1_valid && |s1_hit && !valid) begin
            valid       <= 1'b1;
            bounty      <= sel_hash;
            found_nonce <= s1_nonce + NONCE_W'(sel_lane);
            found_lane  <= sel_lane;
        end
    end

    // Only reset clears the counter.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            hash_count <= '0;
        end else if (accept) begin
            hash_count <= cnt_next;
        end
    end

endmodule

// File: tb/tb_hash_target_cmp.sv
// Directed bench for hash_target_cmp: default instance plus a narrow-counter instance.
module tb_hash_target_cmp;

    logic        clk = 1'b0;
    logic        reset_L;
    logic        enable;
    logic        clear;
    logic        mode;
    logic [23:0] target;
    logic        in_valid;
    logic        in_ready;
    logic [95:0] in_hash;
    logic [31:0] in_nonce;
    logic        valid;
    logic [23:0] bounty;
    logic [31:0] found_nonce;
    logic [1:0]  found_lane;
    logic [31:0] hash_count;

    logic        b_in_valid;
    logic        b_in_ready;
    logic        b_valid;
    logic [23:0] b_bounty;
    logic [31:0] b_found_nonce;
    logic [1:0]  b_found_lane;
    logic [3:0]  b_hash_count;

    int vectors    = 0;
    int miscompares = 0;
    int exp_cnt    = 0;

    always #5 clk = ~clk;

    hash_target_cmp dut (
        .clk         (clk),
        .reset_L     (reset_L),
        .enable      (enable),
        .clear       (clear),
        .mode        (mode),
        .target      (target),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_hash     (in_hash),
        .in_nonce    (in_nonce),
        .valid       (valid),
        .bounty      (bounty),
        .found_nonce (found_nonce),
        .found_lane  (found_lane),
        .hash_count  (hash_count)
    );

    // LT with target 0 never hits, so this instance only exercises counting.
    hash_target_cmp #(
        .CNT_W (4)
    ) dut_sat (
        .clk         (clk),
        .reset_L     (reset_L),
        .enable      (enable),
        .clear       (clear),
        .mode        (1'b0),
        .target      (24'h0),
        .in_valid    (b_in_valid),
        .in_ready    (b_in_ready),
        .in_hash     (in_hash),
        .in_nonce    (in_nonce),
        .valid       (b_valid),
        .bounty      (b_bounty),
        .found_nonce (b_found_nonce),
        .found_lane  (b_found_lane),
        .hash_count  (b_hash_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [95:0] h, input logic [31:0] n);
        in_hash  = h;
        in_nonce = n;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        reset_L    = 1'b0;
        enable     = 1'b1;
        clear      = 1'b0;
        mode       = 1'b0;
        target     = '0;
        in_valid   = 1'b0;
        in_hash    = '0;
        in_nonce   = '0;
        b_in_valid = 1'b0;
        #3;
        chk("rst_valid", 64'(valid), 64'h0);
        chk("rst_bounty", 64'(bounty), 64'h0);
        chk("rst_nonce", 64'(found_nonce), 64'h0);
        chk("rst_lane", 64'(found_lane), 64'h0);
        chk("rst_count", 64'(hash_count), 64'h0);
        @(negedge clk);
        reset_L = 1'b1;
        tick();
        chk("rst_ready", 64'(in_ready), 64'h1);

        // Basic LT match
        mode = 1'b0; target = 24'h001000;
        beat({24'hFFFFFF, 24'h200000, 24'h000FFF, 24'h0FFFFF}, 32'h100);
        exp_cnt = 4;
        chk("t1_latency", 64'(valid), 64'h0);
        chk("t1_count", 64'(hash_count), 64'(exp_cnt));
        tick();
        chk("t1_valid", 64'(valid), 64'h1);
        chk("t1_bounty", 64'(bounty), 64'h000FFF);
        chk("t1_nonce", 64'(found_nonce), 64'h101);
        chk("t1_lane", 64'(found_lane), 64'h1);
        chk("t1_ready", 64'(in_ready), 64'h0);

        // Sticky: blocked winning beat changes nothing
        beat({24'h0, 24'h0, 24'h0, 24'h0}, 32'h150);
        tick();
        chk("st_bounty", 64'(bounty), 64'h000FFF);
        chk("st_nonce", 64'(found_nonce), 64'h101);
        chk("st_count", 64'(hash_count), 64'(exp_cnt));

        // Clear with simultaneous beat: beat dropped
        in_hash = '0; in_nonce = 32'h160; in_valid = 1'b1; clear = 1'b1;
        tick();
        in_valid = 1'b0; clear = 1'b0;
        chk("clr_valid", 64'(valid), 64'h0);
        chk("clr_ready", 64'(in_ready), 64'h1);
        chk("clr_bounty", 64'(bounty), 64'h0);
        chk("clr_count", 64'(hash_count), 64'(exp_cnt));
        tick();
        chk("clr_nohit", 64'(valid), 64'h0);

        // Priority and strict-less-than boundary
        target = 24'h000010;
        beat({24'h000000, 24'h000001, 24'h00000F, 24'h000010}, 32'h200);
        exp_cnt += 4;
        tick();
        chk("t2_lane", 64'(found_lane), 64'h1);
        chk("t2_bounty", 64'(bounty), 64'h00000F);
        chk("t2_nonce", 64'(found_nonce), 64'h201);
        do_clear();
        target = 24'h0;
        beat({24'h0, 24'h0, 24'h0, 24'h0}, 32'h300);
        exp_cnt += 4;
        tick();
        chk("t2_t0_nohit", 64'(valid), 64'h0);
        chk("t2_count", 64'(hash_count), 64'(exp_cnt));

        // LZ mode
        mode = 1'b1; target = 24'd8;
        beat({24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'h00FFFF}, 32'h400);
        exp_cnt += 4;
        tick();
        chk("t3_valid", 64'(valid), 64'h1);
        chk("t3_bounty", 64'(bounty), 64'h00FFFF);
        chk("t3_nonce", 64'(found_nonce), 64'h400);
        do_clear();
        beat({24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'h01FFFF}, 32'h410);
        exp_cnt += 4;
        tick();
        chk("t3_lz7_nohit", 64'(valid), 64'h0);
        target = 24'd0;
        beat({24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF}, 32'h500);
        exp_cnt += 4;
        tick();
        chk("t3_lz0_hit", 64'(valid), 64'h1);
        chk("t3_lz0_bounty", 64'(bounty), 64'hFFFFFF);
        chk("t3_lz0_nonce", 64'(found_nonce), 64'h500);
        do_clear();
        target = 24'd25;
        beat({24'h0, 24'h0, 24'h0, 24'h0}, 32'h580);
        exp_cnt += 4;
        tick();
        chk("t3_lz25_nohit", 64'(valid), 64'h0);
        target = 24'd24;
        beat({24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'hFFFFFF}, 32'h600);
        exp_cnt += 4;
        tick();
        chk("t3_lz24_valid", 64'(valid), 64'h1);
        chk("t3_lz24_lane", 64'(found_lane), 64'h2);
        chk("t3_lz24_nonce", 64'(found_nonce), 64'h602);
        chk("t3_count", 64'(hash_count), 64'(exp_cnt));

        // In-flight beat keeps sampled mode/target and completes with enable low; nonce wraps
        do_clear();
        mode = 1'b0; target = 24'h001000;
        beat({24'h000ABC, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF}, 32'hFFFF_FFFE);
        exp_cnt += 4;
        mode = 1'b1; target = 24'd0; enable = 1'b0;
        tick();
        chk("fl_valid", 64'(valid), 64'h1);
        chk("fl_lane", 64'(found_lane), 64'h3);
        chk("fl_nonce", 64'(found_nonce), 64'h1);
        chk("fl_bounty", 64'(bounty), 64'h000ABC);
        do_clear();
        beat({24'h0, 24'h0, 24'h0, 24'h0}, 32'h700);
        tick();
        chk("en0_valid", 64'(valid), 64'h0);
        chk("en0_count", 64'(hash_count), 64'(exp_cnt));
        enable = 1'b1;

        // Back-to-back winners: capture holds the first
        mode = 1'b0; target = 24'h001000;
        in_hash = {24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'h000001};
        in_nonce = 32'h800; in_valid = 1'b1;
        tick();
        in_hash = {24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'h000002};
        in_nonce = 32'h900;
        tick();
        in_valid = 1'b0;
        exp_cnt += 8;
        chk("b2b_valid", 64'(valid), 64'h1);
        chk("b2b_bounty", 64'(bounty), 64'h000001);
        chk("b2b_nonce", 64'(found_nonce), 64'h800);
        chk("b2b_count", 64'(hash_count), 64'(exp_cnt));
        tick();
        chk("b2b_hold_bounty", 64'(bounty), 64'h000001);
        chk("b2b_hold_nonce", 64'(found_nonce), 64'h800);

        // Async reset with a beat in stage 1
        do_clear();
        beat({24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'h000001}, 32'hA00);
        #2;
        reset_L = 1'b0;
        #1;
        chk("ar_valid", 64'(valid), 64'h0);
        chk("ar_count", 64'(hash_count), 64'h0);
        chk("ar_bounty", 64'(bounty), 64'h0);
        chk("ar_ready", 64'(in_ready), 64'h1);
        @(negedge clk);
        reset_L = 1'b1;
        tick();
        tick();
        chk("ar_no_valid", 64'(valid), 64'h0);

        // Counter saturation on the narrow instance
        b_in_valid = 1'b1;
        repeat (5) tick();
        chk("sat_count", 64'(b_hash_count), 64'hF);
        repeat (2) tick();
        b_in_valid = 1'b0;
        chk("sat_hold", 64'(b_hash_count), 64'hF);
        chk("sat_main_count", 64'(hash_count), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
